// File: rtl/rgb_led_pkg.sv
// Shared types and colour constants for the RGB LED blocks.
// Colours are active-high {r,g,b}; pins invert them.
package rgb_led_pkg;

  typedef logic [2:0] color_t;

  localparam color_t C_OFF     = 3'b000;
  localparam color_t C_RED     = 3'b100;
  localparam color_t C_YELLOW  = 3'b110;
  localparam color_t C_GREEN   = 3'b010;
  localparam color_t C_CYAN    = 3'b011;
  localparam color_t C_BLUE    = 3'b001;
  localparam color_t C_MAGENTA = 3'b101;
  localparam color_t C_WHITE   = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    OWNED,
    GAP
  } sched_state_t;

endpackage

// File: rtl/led_tick_gen.sv
// Free-running prescaler producing a one-cycle tick
// each time the counter wraps back to zero.
module led_tick_gen #(
  parameter int CLK_HZ  = 12000000,
  parameter int TICK_HZ = 1000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int CW  = $clog2(DIV);

  logic [CW-1:0] cnt;

  // Count 0..DIV-1 and flag the wrap on the following cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == CW'(DIV - 1));
      if (cnt == CW'(DIV - 1)) cnt <= '0;
      else                     cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/rgb_led_scheduler.sv
// Round-robin owner of the shared RGB LED with
// min/max hold times and a blank gap between owners.
module rgb_led_scheduler
  import rgb_led_pkg::*;
#(
  parameter int CLK_HZ         = 12000000,
  parameter int TICK_HZ        = 1000,
  parameter int NUM_REQ        = 4,
  parameter int MIN_HOLD_TICKS = 250,
  parameter int MAX_HOLD_TICKS = 1000,
  parameter int GAP_TICKS      = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [3*NUM_REQ-1:0] color_in,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 RGB_R,
  output logic                 RGB_G,
  output logic                 RGB_B
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int HW = $clog2(MAX_HOLD_TICKS + 1);
  localparam int GW = $clog2(GAP_TICKS + 1);

  sched_state_t  state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] owner;
  logic [HW-1:0] hold_cnt;
  logic [GW-1:0] gap_cnt;
  color_t        col_q;
  logic [2:0]    rgb_n;
  logic          tick;

  logic          win_vld;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] nxt_ptr;
  logic          owner_req;
  logic          others;
  logic          at_min;
  logic          at_max;
  logic          release_now;
  color_t        own_col;

  led_tick_gen #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // First asserted request at or after rr_ptr, wrapping
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      automatic int idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx]) begin
        win_vld = 1'b1;
        win_idx = IW'(idx);
      end
    end
  end

  // Only the owner's colour slice is ever selected
  always_comb begin
    own_col     = color_t'(color_in[3*int'(owner) +: 3]);
    owner_req   = req[owner];
    others      = |(req & ~grant);
    at_min      = (hold_cnt >= HW'(MIN_HOLD_TICKS));
    at_max      = (hold_cnt >= HW'(MAX_HOLD_TICKS));
    release_now = (!owner_req && at_min) || (at_max && others);
    nxt_ptr     = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + IW'(1);
  end

  // Arbitration, hold timing and registered LED drive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      hold_cnt <= '0;
      gap_cnt  <= '0;
      col_q    <= C_OFF;
      grant    <= '0;
      busy     <= 1'b0;
      rgb_n    <= ~C_OFF;
    end else begin
      unique case (state)
        IDLE: begin
          rgb_n <= ~C_OFF;
          if (win_vld) begin
            state    <= OWNED;
            owner    <= win_idx;
            grant    <= NUM_REQ'(1) << win_idx;
            rr_ptr   <= nxt_ptr;
            hold_cnt <= '0;
            col_q    <= C_OFF;
            busy     <= 1'b1;
          end
        end
        OWNED: begin
          if (release_now) begin
            state   <= GAP;
            grant   <= '0;
            gap_cnt <= '0;
            rgb_n   <= ~C_OFF;
          end else begin
            if (owner_req) begin
              col_q <= own_col;
              rgb_n <= ~own_col;
            end else begin
              rgb_n <= ~col_q;
            end
            if (at_max)    hold_cnt <= '0;
            else if (tick) hold_cnt <= hold_cnt + HW'(1);
          end
        end
        GAP: begin
          rgb_n <= ~C_OFF;
          if (tick) begin
            gap_cnt <= gap_cnt + GW'(1);
            if (gap_cnt == GW'(GAP_TICKS - 1)) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign RGB_R = rgb_n[2];
  assign RGB_G = rgb_n[1];
  assign RGB_B = rgb_n[0];

endmodule

// File: tb/tb_rgb_led_scheduler.sv
// Directed + random bench for rgb_led_scheduler
// against a cycle-level behavioural model.
module tb_rgb_led_scheduler;

  localparam int N    = 4;
  localparam int MINH = 3;
  localparam int MAXH = 8;
  localparam int GAPT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [11:0] color_in = '0;
  logic [3:0]  grant;
  logic        busy;
  logic        RGB_R, RGB_G, RGB_B;

  int checks = 0;
  int errors = 0;

  // model: 0 idle, 1 owned, 2 gap
  int         m_st, m_own, m_ptr, m_hold, m_gap, m_n;
  logic [2:0] m_col;
  logic [3:0] e_grant;
  logic       e_busy;
  logic [2:0] e_rgb;

  rgb_led_scheduler #(
    .CLK_HZ         (100),
    .TICK_HZ        (10),
    .NUM_REQ        (N),
    .MIN_HOLD_TICKS (MINH),
    .MAX_HOLD_TICKS (MAXH),
    .GAP_TICKS      (GAPT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .color_in (color_in),
    .grant    (grant),
    .busy     (busy),
    .RGB_R    (RGB_R),
    .RGB_G    (RGB_G),
    .RGB_B    (RGB_B)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_own = 0; m_ptr = 0; m_hold = 0;
    m_gap = 0; m_n = 0; m_col = 3'b000;
    e_grant = '0; e_busy = 1'b0; e_rgb = 3'b111;
  endtask

  // One clock edge of the scheduler rules; ticks land on
  // edges 11, 21, 31 ... after reset release.
  task automatic model_edge(input logic [3:0] r, input logic [11:0] c);
    bit tk;
    bit oth;
    tk = (m_n >= 11) && (m_n % 10 == 1);
    if (m_st == 0) begin
      e_rgb = 3'b111;
      if (r != 0) begin
        for (int k = N - 1; k >= 0; k--)
          if (r[(m_ptr + k) % N]) m_own = (m_ptr + k) % N;
        m_ptr = (m_own + 1) % N;
        m_hold = 0;
        m_col = 3'b000;
        m_st = 1;
      end
    end else if (m_st == 1) begin
      oth = (r & ~(4'b1 << m_own)) != 0;
      if ((!r[m_own] && m_hold >= MINH) || (m_hold >= MAXH && oth)) begin
        m_st = 2;
        m_gap = 0;
        e_rgb = 3'b111;
      end else begin
        if (r[m_own]) m_col = c[3*m_own +: 3];
        e_rgb = ~m_col;
        if (m_hold >= MAXH) m_hold = 0;
        else if (tk) m_hold++;
      end
    end else begin
      e_rgb = 3'b111;
      if (tk) begin
        m_gap++;
        if (m_gap >= GAPT) m_st = 0;
      end
    end
    e_grant = (m_st == 1) ? (4'b1 << m_own) : 4'b0;
    e_busy  = (m_st != 0);
  endtask

  // Advance one edge, update the model, compare at edge+1
  task automatic step();
    logic [3:0]  r;
    logic [11:0] c;
    @(posedge clk);
    r = req;
    c = color_in;
    if (rst_n) begin
      m_n++;
      model_edge(r, c);
    end else begin
      model_reset();
    end
    #1;
    chk("cycle", {grant, busy, RGB_R, RGB_G, RGB_B},
        {e_grant, e_busy, e_rgb});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] seq [$];
    logic [3:0] prev;
    logic [3:0] exp_seq [4];
    logic [3:0] r;
    logic [11:0] c;
    bit done;

    model_reset();

    // Reset with all requests high
    req = 4'b1111;
    color_in = {3'b001, 3'b010, 3'b100, 3'b111};
    repeat (3) step();
    chk("rst_grant", grant, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rgb", {RGB_R, RGB_G, RGB_B}, 3'b111);
    rst_n = 1'b1;
    step();
    chk("rst_first_grant", grant, 4'b0001);
    req = 4'b0000;
    repeat (60) step();
    chk("drop_idle_busy", busy, 1'b0);

    // Single owner, then early drop
    req = 4'b0100;
    color_in = {3'bxxx, 3'b100, 3'bxxx, 3'bxxx};
    step();
    chk("single_grant", grant, 4'b0100);
    step();
    chk("single_rgb", {RGB_R, RGB_G, RGB_B}, 3'b011);
    repeat (10) step();
    req = 4'b0000;
    color_in = 12'hxxx;
    step();
    chk("early_hold_grant", grant, 4'b0100);
    chk("early_hold_rgb", {RGB_R, RGB_G, RGB_B}, 3'b011);
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      step();
      if (busy == 1'b0) done = 1;
    end
    chk("early_reaches_idle", done, 1'b1);

    // Async reset while owned
    req = 4'b0001;
    color_in = {9'b0, 3'b010};
    repeat (3) step();
    chk("async_pre_grant", grant, 4'b0001);
    #2 rst_n = 1'b0;
    #1;
    chk("async_grant", grant, 4'b0000);
    chk("async_rgb", {RGB_R, RGB_G, RGB_B}, 3'b111);
    chk("async_busy", busy, 1'b0);
    model_reset();
    req = 4'b0000;
    step();
    step();
    rst_n = 1'b1;

    // Round robin with 1011 held
    req = 4'b1011;
    color_in = {3'b001, 3'b011, 3'b110, 3'b100};
    exp_seq = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
    prev = 4'b0000;
    for (int i = 0; i < 800 && seq.size() < 4; i++) begin
      step();
      if (grant != prev && grant != 4'b0000) seq.push_back(grant);
      prev = grant;
    end
    chk("rr_count", seq.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("rr_order%0d", i),
          (i < seq.size()) ? seq[i] : 4'b0000, exp_seq[i]);

    // Sole owner beyond max hold
    req = 4'b0000;
    do_reset();
    req = 4'b0010;
    color_in = {6'b0, 3'b101, 3'b0};
    step();
    chk("sole_grant", grant, 4'b0010);
    for (int i = 0; i < 300; i++) begin
      step();
      chk("sole_keep", {grant, RGB_R, RGB_G, RGB_B}, {4'b0010, 3'b010});
    end

    // Randomized traffic
    req = 4'b0000;
    do_reset();
    r = 4'b0000;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(7) == 0) r = 4'($urandom);
      for (int j = 0; j < 4; j++)
        c[3*j +: 3] = r[j] ? 3'($urandom) : 3'bxxx;
      req = r;
      color_in = c;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
